// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC owner and prefetch FIFO between instruction memory and datapath
module instruction_fetch_unit #(
    parameter int ADDR_W = 8,
    parameter int INS_W  = 8,
    parameter int DEPTH  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic [ADDR_W-1:0]          ins_address,
    input  logic [INS_W-1:0]           ins_bus,
    output logic                       ins_valid,
    input  logic                       ins_ready,
    output logic [INS_W-1:0]           ins_out,
    output logic [ADDR_W-1:0]          ins_pc,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_pc,
    input  logic                       halt,
    output logic [$clog2(DEPTH):0]     fill_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic {FETCH = 1'b0, HALTED = 1'b1} state_t;

    state_t state_q;
    state_t state_d;
    logic   fetch_en;

    logic [ADDR_W-1:0] pc;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W:0]    count;
    logic [INS_W-1:0]  mem_ins [DEPTH];
    logic [ADDR_W-1:0] mem_pc  [DEPTH];
    logic [INS_W-1:0]  last_ins;
    logic [ADDR_W-1:0] last_pc;
    logic              push;
    logic              pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Halt is a level: the state simply follows it; redirect never touches state.
    always_comb begin
        state_d = state_q;
        if (halt) begin
            state_d = HALTED;
        end else begin
            state_d = FETCH;
        end
    end

    always_comb begin
        fetch_en = 1'b0;
        case (state_q)
            FETCH:   fetch_en = 1'b1;
            HALTED:  fetch_en = 1'b0;
            default: fetch_en = 1'b0;
        endcase
    end

    assign ins_valid   = (count != '0);
    assign pop         = ins_valid && ins_ready && !redirect;
    assign push        = fetch_en && !halt && !redirect && ((count < FULL_COUNT) || pop);
    assign ins_address = pc;
    assign fill_level  = count;

    // When empty, present the last head seen rather than a stale slot.
    assign ins_out = ins_valid ? mem_ins[rd_ptr] : last_ins;
    assign ins_pc  = ins_valid ? mem_pc[rd_ptr]  : last_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            last_ins <= '0;
            last_pc  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_ins[i] <= '0;
                mem_pc[i]  <= '0;
            end
        end else begin
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
                pc     <= redirect_pc;
            end else begin
                if (push) begin
                    mem_ins[wr_ptr] <= ins_bus;
                    mem_pc[wr_ptr]  <= pc;
                    wr_ptr          <= wr_ptr + 1'b1;
                    pc              <= pc + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push && !pop) begin
                    count <= count + 1'b1;
                end else if (pop && !push) begin
                    count <= count - 1'b1;
                end
            end
            if (ins_valid) begin
                last_ins <= mem_ins[rd_ptr];
                last_pc  <= mem_pc[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed vector bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ins_address;
    logic [7:0] ins_bus;
    logic       ins_valid;
    logic       ins_ready = 1'b1;
    logic [7:0] ins_out;
    logic [7:0] ins_pc;
    logic       redirect = 1'b0;
    logic [7:0] redirect_pc = 8'h00;
    logic       halt = 1'b0;
    logic [2:0] fill_level;

    logic [7:0] w_address;
    logic [7:0] w_bus;
    logic       w_valid;
    logic [7:0] w_out;
    logic [7:0] w_pc;
    logic [2:0] w_fill;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instruction memory model: memory[i] = i + 8'h10
    assign ins_bus = ins_address + 8'h10;
    assign w_bus   = w_address + 8'h10;

    instruction_fetch_unit #(.ADDR_W(8), .INS_W(8), .DEPTH(4), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .ins_address(ins_address), .ins_bus(ins_bus),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_out(ins_out), .ins_pc(ins_pc),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt), .fill_level(fill_level)
    );

    instruction_fetch_unit #(.ADDR_W(8), .INS_W(8), .DEPTH(4), .RESET_PC(8'hFE)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .ins_address(w_address), .ins_bus(w_bus),
        .ins_valid(w_valid), .ins_ready(1'b1), .ins_out(w_out), .ins_pc(w_pc),
        .redirect(1'b0), .redirect_pc(8'h00), .halt(1'b0), .fill_level(w_fill)
    );

    typedef struct {
        bit         rst;
        logic       ready;
        logic       redir;
        logic [7:0] rpc;
        logic       hlt;
        logic       e_valid;
        logic [7:0] e_pc;
        logic [2:0] e_fill;
        logic [7:0] e_addr;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input bit r, input logic rdy, input logic rd, input logic [7:0] rp, input logic h,
                       input logic ev, input logic [7:0] ep, input logic [2:0] ef, input logic [7:0] ea);
        vec_t v;
        v.rst = r; v.ready = rdy; v.redir = rd; v.rpc = rp; v.hlt = h;
        v.e_valid = ev; v.e_pc = ep; v.e_fill = ef; v.e_addr = ea;
        vecs.push_back(v);
    endtask

    initial begin
        // reset
        add(1, 1, 0, 8'h00, 0,  0, 8'h00, 0, 8'h00);
        // free run
        add(0, 1, 0, 8'h00, 0,  1, 8'h00, 1, 8'h01);
        add(0, 1, 0, 8'h00, 0,  1, 8'h01, 1, 8'h02);
        add(0, 1, 0, 8'h00, 0,  1, 8'h02, 1, 8'h03);
        // backpressure from empty
        add(1, 0, 0, 8'h00, 0,  0, 8'h00, 0, 8'h00);
        add(0, 0, 0, 8'h00, 0,  1, 8'h00, 1, 8'h01);
        add(0, 0, 0, 8'h00, 0,  1, 8'h00, 2, 8'h02);
        add(0, 0, 0, 8'h00, 0,  1, 8'h00, 3, 8'h03);
        add(0, 0, 0, 8'h00, 0,  1, 8'h00, 4, 8'h04);
        add(0, 0, 0, 8'h00, 0,  1, 8'h00, 4, 8'h04);
        add(0, 0, 0, 8'h00, 0,  1, 8'h00, 4, 8'h04);
        // release: full FIFO with push and pop together
        add(0, 1, 0, 8'h00, 0,  1, 8'h01, 4, 8'h05);
        add(0, 1, 0, 8'h00, 0,  1, 8'h02, 4, 8'h06);
        add(0, 1, 0, 8'h00, 0,  1, 8'h03, 4, 8'h07);
        add(0, 1, 0, 8'h00, 0,  1, 8'h04, 4, 8'h08);
        // leave 3 queued, then redirect with a live handshake
        add(0, 1, 0, 8'h00, 1,  1, 8'h05, 3, 8'h08);
        add(0, 1, 1, 8'h80, 0,  0, 8'h00, 0, 8'h80);
        add(0, 1, 0, 8'h00, 0,  1, 8'h80, 1, 8'h81);
        add(0, 1, 0, 8'h00, 0,  1, 8'h81, 1, 8'h82);
        // fill to 4
        add(0, 0, 0, 8'h00, 0,  1, 8'h81, 2, 8'h83);
        add(0, 0, 0, 8'h00, 0,  1, 8'h81, 3, 8'h84);
        add(0, 0, 0, 8'h00, 0,  1, 8'h81, 4, 8'h85);
        // halt while full: drain, address frozen
        add(0, 1, 0, 8'h00, 1,  1, 8'h82, 3, 8'h85);
        add(0, 1, 0, 8'h00, 1,  1, 8'h83, 2, 8'h85);
        add(0, 1, 0, 8'h00, 1,  1, 8'h84, 1, 8'h85);
        add(0, 1, 0, 8'h00, 1,  0, 8'h00, 0, 8'h85);
        add(0, 1, 0, 8'h00, 1,  0, 8'h00, 0, 8'h85);
        // redirect while halted
        add(0, 1, 1, 8'h20, 1,  0, 8'h00, 0, 8'h20);
        add(0, 1, 0, 8'h00, 1,  0, 8'h00, 0, 8'h20);
        // unhalt: 0x20 arrives two cycles later
        add(0, 1, 0, 8'h00, 0,  0, 8'h00, 0, 8'h20);
        add(0, 1, 0, 8'h00, 0,  1, 8'h20, 1, 8'h21);
        add(0, 1, 0, 8'h00, 0,  1, 8'h21, 1, 8'h22);

        // PC wrap on the RESET_PC=FE instance
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [7:0] exp_pc;
            exp_pc = 8'hFE + 8'(k);
            @(posedge clk); #1;
            check("wrap_valid", k, 32'(w_valid), 32'd1);
            check("wrap_pc", k, 32'(w_pc), 32'(exp_pc));
            check("wrap_out", k, 32'(w_out), 32'(8'(exp_pc + 8'h10)));
        end

        for (int i = 0; i < vecs.size(); i++) begin
            ins_ready   = vecs[i].ready;
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            halt        = vecs[i].hlt;
            if (vecs[i].rst) begin
                @(negedge clk);
                rst_n = 1'b0;
                #1;
                check("rst_out", i, 32'(ins_out), 32'd0);
                check("rst_pc", i, 32'(ins_pc), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                @(posedge clk); #1;
                if (vecs[i].e_valid) begin
                    check("head_pc", i, 32'(ins_pc), 32'(vecs[i].e_pc));
                    check("head_out", i, 32'(ins_out), 32'(8'(vecs[i].e_pc + 8'h10)));
                end
            end
            check("valid", i, 32'(ins_valid), 32'(vecs[i].e_valid));
            check("fill", i, 32'(fill_level), 32'(vecs[i].e_fill));
            check("addr", i, 32'(ins_address), 32'(vecs[i].e_addr));
        end

        // asynchronous reset between edges while streaming
        ins_ready = 1'b1; redirect = 1'b0; halt = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        check("pre_async_valid", 0, 32'(ins_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_valid", 0, 32'(ins_valid), 32'd0);
        check("async_fill", 0, 32'(fill_level), 32'd0);
        check("async_addr", 0, 32'(ins_address), 32'd0);
        check("async_wrap_addr", 0, 32'(w_address), 32'hFE);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("restart_pc", 0, 32'(ins_pc), 32'd0);
        check("restart_valid", 0, 32'(ins_valid), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
